// File: rtl/pc_fetch_unit.sv
// Fetch PC holder: issues one word fetch at a time, buffers returned
// instructions with their PCs for decode, and flushes on redirect.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        misaligned
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          pending_q, pending_d;
   logic          drop_q, drop_d;
   logic          misaligned_q, misaligned_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   buf_data_q [BUF_DEPTH];
   logic [31:0]   buf_pc_q   [BUF_DEPTH];

   logic req_fire, resp_fire, push, pop;

   // Valid/ready: a transfer happens on any rising edge where both valid and
   // ready are high; valid never depends on ready on any channel here.
   assign imem_req_valid = !rst && !pending_q && !misaligned_q && !redirect_valid
                           && (count_q < DEPTH_C);
   assign imem_req_addr  = fetch_pc_q;
   assign inst_valid     = !rst && (count_q != '0);
   assign inst_data      = buf_data_q[head_q];
   assign inst_pc        = buf_pc_q[head_q];
   assign misaligned     = misaligned_q;

   assign req_fire  = imem_req_valid && imem_req_ready;
   assign resp_fire = imem_resp_valid && pending_q;
   assign push      = resp_fire && !drop_q && !redirect_valid;
   assign pop       = inst_valid && inst_ready && !redirect_valid;

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      pending_d    = pending_q;
      drop_d       = drop_q;
      misaligned_d = misaligned_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      if (redirect_valid) begin
         head_d       = '0;
         tail_d       = '0;
         count_d      = '0;
         fetch_pc_d   = redirect_pc;
         misaligned_d = |redirect_pc[1:0];
         // A still-outstanding fetch must be swallowed when it returns.
         pending_d    = pending_q && !imem_resp_valid;
         drop_d       = pending_q && !imem_resp_valid;
      end else begin
         if (req_fire) begin
            pending_d  = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (resp_fire) begin
            pending_d = 1'b0;
            drop_d    = 1'b0;
         end
         if (push) tail_d = tail_q + PW'(1);
         if (pop)  head_d = head_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= RESET_PC;
         pending_q    <= 1'b0;
         drop_q       <= 1'b0;
         misaligned_q <= 1'b0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         pending_q    <= pending_d;
         drop_q       <= drop_d;
         misaligned_q <= misaligned_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         buf_data_q[tail_q] <= imem_resp_data;
         buf_pc_q[tail_q]   <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: in-order variable-latency memory model
// plus a linear sequence of hand-timed steps checked with immediate asserts.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        misaligned;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int obs_cyc     = 0;
   int lat         = 1;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc),
      .misaligned      (misaligned)
   );

   // clock / cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Memory model: samples the request just before each rising edge, answers
   // 'lat' edges after acceptance, driving response signals on falling edges.
   initial begin
      logic        fire;
      logic [31:0] f_addr;
      logic        busy;
      int          cnt;
      logic [31:0] addr;
      fire = 1'b0;
      f_addr = '0;
      busy = 1'b0;
      cnt = 0;
      addr = '0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         imem_resp_valid = 1'b0;
         if (busy) begin
            cnt--;
            if (cnt <= 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_word(addr);
               busy = 1'b0;
            end
         end
         if (fire) begin
            addr = f_addr;
            cnt  = lat - 1;
            busy = 1'b1;
            if (cnt <= 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_word(addr);
               busy = 1'b0;
            end
         end
         #4;
         fire   = imem_req_valid && imem_req_ready;
         f_addr = imem_req_addr;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a decode handshake, checks it, then moves to the
   // falling edge after the pop.
   task automatic wait_inst(input logic [31:0] exp_pc, input string tag);
      int n;
      n = 0;
      while (!(inst_valid && inst_ready) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_seen"}, {31'd0, inst_valid && inst_ready}, 32'd1);
      chk({tag, "_pc"}, inst_pc, exp_pc);
      chk({tag, "_data"}, inst_data, mem_word(exp_pc));
      obs_cyc = cyc;
      @(negedge clk);
   endtask

   task automatic do_reset(input int new_lat);
      rst = 1'b1;
      redirect_valid = 1'b0;
      @(negedge clk);
      #2 lat = new_lat;
      repeat (4) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int t0;
      int prev;
      int r;
      int reqs;
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;

      // reset state and steady streaming, one instruction every two cycles
      repeat (3) @(negedge clk);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
      rst = 1'b0;
      t0 = cyc;
      wait_inst(32'h0, "seq0");
      chk("seq_first_latency", obs_cyc - t0, 32'd2);
      for (int i = 1; i < 4; i++) begin
         prev = obs_cyc;
         wait_inst(32'(i * 4), "seq");
         chk("seq_gap", obs_cyc - prev, 32'd2);
      end

      // decode stall fills the buffer and blocks fetch
      inst_ready = 1'b0;
      repeat (10) @(negedge clk);
      chk("full_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("full_head_pc", inst_pc, 32'h10);
      chk("full_req_blocked", {31'd0, imem_req_valid}, 32'd0);
      inst_ready = 1'b1;
      wait_inst(32'h10, "drain0");
      chk("drain_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("drain_req_addr", imem_req_addr, 32'h18);
      wait_inst(32'h14, "drain1");
      wait_inst(32'h18, "drain2");

      // redirect while a slow fetch of 0x8 is outstanding and 0x4 is buffered
      do_reset(3);
      wait_inst(32'h0, "slow0");
      inst_ready = 1'b0;
      repeat (4) @(negedge clk);
      chk("slow_buf_pc", inst_pc, 32'h4);
      chk("slow_buf_valid", {31'd0, inst_valid}, 32'd1);
      chk("slow_pending", {31'd0, imem_req_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0;
      inst_ready = 1'b1;
      #1;
      chk("redir_flush", {31'd0, inst_valid}, 32'd0);
      chk("redir_wait_stale", {31'd0, imem_req_valid}, 32'd0);
      wait_inst(32'h100, "redir_tgt");

      // redirect in the same cycle as the response for 0x4
      do_reset(1);
      wait_inst(32'h0, "same0");
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      r = cyc;
      redirect_valid = 1'b0;
      #1;
      chk("same_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("same_req_addr", imem_req_addr, 32'h40);
      chk("same_inst_valid", {31'd0, inst_valid}, 32'd0);
      wait_inst(32'h40, "same_tgt");
      chk("same_latency", obs_cyc - r, 32'd2);

      // misaligned target halts fetch until an aligned redirect
      redirect_valid = 1'b1;
      redirect_pc = 32'h102;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("mis_flag", {31'd0, misaligned}, 32'd1);
      chk("mis_inst_valid", {31'd0, inst_valid}, 32'd0);
      reqs = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req_valid) reqs++;
      end
      chk("mis_no_req", reqs, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h180;
      @(negedge clk);
      redirect_pc = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("mis_clear", {31'd0, misaligned}, 32'd0);
      chk("b2b_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("b2b_req_addr", imem_req_addr, 32'h200);
      wait_inst(32'h200, "b2b0");
      wait_inst(32'h204, "b2b1");

      // address wrap, then reset with a fetch still in flight
      #2 lat = 3;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_inst(32'hFFFF_FFFC, "wrap0");
      wait_inst(32'h0, "wrap1");
      imem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("stale_ignored", {31'd0, inst_valid}, 32'd0);
      chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("post_rst_req_addr", imem_req_addr, 32'h0);
      imem_req_ready = 1'b1;
      wait_inst(32'h0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
